// File: rtl/jk_register_bank.sv
// Bank of WIDTH clocked JK flip-flops with parallel-load and up/down count modes.
// Also provides registered terminal-count (tc) and change-detect (chg) flags.
module jk_register_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             chg
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] next_q;
  logic             next_tc;

  // JK per bit reduces to q' = (q & ~k) | (~q & j): hold, clear, set or toggle.
  always_comb begin
    next_q  = q;
    next_tc = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK:   next_q = (q & ~k) | (~q & j);
        MODE_LOAD: next_q = j;
        MODE_UP: begin
          if (q == ALL_ONES) begin
            next_tc = 1'b1;
            next_q  = SATURATE ? q : ZERO;
          end else begin
            next_q = q + ONE;
          end
        end
        MODE_DOWN: begin
          if (q == ZERO) begin
            next_tc = 1'b1;
            next_q  = SATURATE ? q : ALL_ONES;
          end else begin
            next_q = q - ONE;
          end
        end
        default: next_q = q;
      endcase
    end
  end

  // With en=0 next_q equals q, so chg naturally drops to 0 on a disabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= RESET_VAL;
      tc  <= 1'b0;
      chg <= 1'b0;
    end else begin
      q   <= next_q;
      tc  <= next_tc;
      chg <= (next_q != q);
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and are
// compared against an arithmetic reference model after every clock edge.
module tb_jk_register_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = 8'h00;
  logic [7:0] k = 8'h00;

  logic [7:0] q_w, qb_w, q_s, qb_s;
  logic       tc_w, chg_w, tc_s, chg_s;

  int checks = 0;
  int failures = 0;

  int mq[2];
  bit mtc[2];
  bit mchg[2];

  always #5 clk = ~clk;

  jk_register_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .q(q_w), .qb(qb_w), .tc(tc_w), .chg(chg_w)
  );

  jk_register_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .q(q_s), .qb(qb_s), .tc(tc_s), .chg(chg_s)
  );

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    cmp({tag, " wrap.q"},   q_w,  8'(mq[0]));
    cmp({tag, " wrap.qb"},  qb_w, 8'(255 - mq[0]));
    cmp({tag, " wrap.tc"},  {7'd0, tc_w},  {7'd0, mtc[0]});
    cmp({tag, " wrap.chg"}, {7'd0, chg_w}, {7'd0, mchg[0]});
    cmp({tag, " sat.q"},    q_s,  8'(mq[1]));
    cmp({tag, " sat.qb"},   qb_s, 8'(255 - mq[1]));
    cmp({tag, " sat.tc"},   {7'd0, tc_s},  {7'd0, mtc[1]});
    cmp({tag, " sat.chg"},  {7'd0, chg_s}, {7'd0, mchg[1]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 'hA5;
      mtc[i] = 1'b0;
      mchg[i] = 1'b0;
    end
  endtask

  // Reference behaviour written from the mode rules with integer arithmetic.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int nq;
      bit ntc;
      bit sat;
      sat = (i == 1);
      nq = mq[i];
      ntc = 1'b0;
      if (en) begin
        case (mode)
          2'b00: begin
            for (int b = 0; b < 8; b++) begin
              if (j[b] && k[b]) nq = nq ^ (1 << b);
              else if (j[b])    nq = nq | (1 << b);
              else if (k[b])    nq = nq & ~(1 << b);
            end
          end
          2'b01: nq = int'(j);
          2'b10: begin
            if (mq[i] == 255) begin
              ntc = 1'b1;
              nq = sat ? 255 : 0;
            end else nq = mq[i] + 1;
          end
          default: begin
            if (mq[i] == 0) begin
              ntc = 1'b1;
              nq = sat ? 0 : 255;
            end else nq = mq[i] - 1;
          end
        endcase
      end
      mchg[i] = (nq != mq[i]);
      mtc[i] = ntc;
      mq[i] = nq;
    end
  endtask

  task automatic apply_stimulus(input bit en_v, input logic [1:0] mode_v,
                                input logic [7:0] j_v, input logic [7:0] k_v);
    en = en_v;
    mode = mode_v;
    j = j_v;
    k = k_v;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  initial begin
    // Asynchronous reset between edges, no clock edge involved
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_output("reset_async");
    @(posedge clk);
    #1;
    check_output("reset_held");
    @(negedge clk);
    rst = 1'b0;

    // JK per-bit behaviour
    apply_stimulus(1'b1, 2'b01, 8'h0F, 8'h00);
    check_output("load_0F");
    apply_stimulus(1'b1, 2'b00, 8'hF0, 8'h3C);
    check_output("jk_F3");
    cmp("jk_F3 literal", q_w, 8'hF3);

    // Up wrap / saturate at all-ones
    apply_stimulus(1'b1, 2'b01, 8'hFE, 8'h00);
    check_output("load_FE");
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(1'b1, 2'b10, 8'h00, 8'h00);
      check_output($sformatf("up_%0d", n));
    end

    // Down wrap / saturate at zero
    apply_stimulus(1'b1, 2'b01, 8'h01, 8'h00);
    check_output("load_01");
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(1'b1, 2'b11, 8'h00, 8'h00);
      check_output($sformatf("down_%0d", n));
    end

    // Enable low holds everything
    for (int n = 0; n < 4; n++) begin
      apply_stimulus(1'b0, 2'b10, 8'hFF, 8'hFF);
      check_output($sformatf("hold_%0d", n));
    end
    apply_stimulus(1'b1, 2'b00, 8'h00, 8'h00);
    check_output("jk_nochange");

    // Randomized traffic, loads biased toward the counter boundaries
    for (int n = 0; n < 300; n++) begin
      logic [1:0] m;
      logic [7:0] jv;
      m = 2'($urandom_range(0, 3));
      jv = 8'($urandom_range(0, 255));
      if (m == 2'b01 && $urandom_range(0, 1) == 1)
        jv = ($urandom_range(0, 1) == 1) ? 8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom_range(0, 1));
      apply_stimulus(($urandom_range(0, 7) != 0), m, jv, 8'($urandom_range(0, 255)));
      check_output($sformatf("rand_%0d", n));
    end

    // Reset asserted mid-count overrides immediately
    apply_stimulus(1'b1, 2'b01, 8'h10, 8'h00);
    check_output("load_10");
    apply_stimulus(1'b1, 2'b10, 8'h00, 8'h00);
    check_output("count_11");
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_output("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b1, 2'b10, 8'h00, 8'h00);
    check_output("resume_A6");
    cmp("resume_A6 literal", q_w, 8'hA6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
